// File: rtl/jogador_automatico.sv
// jogador_automatico: automatic player for the Genius memory game.
// Records each round shown on leds, then replays it on chaves with fixed
// press/release timing once vez_jogador rises.
// Optional build macro JOGADOR_ERRO_INJETADO_EN adds input errar_na_jogada,
// which rotates the replayed entry at that 1-based position to force an error.
module jogador_automatico #(
   parameter int unsigned MAX_JOGADAS = 16, // capture depth, 2..31
   parameter int unsigned T_PRESS     = 3,  // cycles each chave is held, >= 1
   parameter int unsigned T_GAP       = 3,  // cycles of 0000 between presses, >= 1
   parameter int unsigned T_THINK     = 2   // cycles from vez_jogador rise to first press, >= 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilitar,
   input  logic [3:0] leds,
   input  logic       vez_jogador,
   input  logic       acertou,
   input  logic       errou,
   input  logic       timeout,
`ifdef JOGADOR_ERRO_INJETADO_EN
   input  logic [4:0] errar_na_jogada,
`endif
   output logic [3:0] chaves,
   output logic       ocupado,
   output logic       erro_captura,
   output logic       overflow,
   output logic [4:0] num_capturadas,
   output logic [3:0] db_estado
);

   localparam int unsigned AW    = $clog2(MAX_JOGADAS);
   localparam logic [4:0]  MAX_N = 5'(MAX_JOGADAS);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      CAPTURA   = 4'd1,
      PENSA     = 4'd2,
      PRESSIONA = 4'd3,
      SOLTA     = 4'd4,
      AGUARDA   = 4'd5,
      FIM       = 4'd6
   } estado_t;

   estado_t    estado;
   logic [3:0] mem [MAX_JOGADAS];
   logic [3:0] leds_prev;
   logic       vez_prev;
   logic [4:0] indice;
   logic [7:0] timer;

   logic          vez_sobe;
   logic          vez_desce;
   logic          cap_evento;
   logic          cap_grava;
   logic [4:0]    cap_base;
   logic [4:0]    indice_prox;
   logic [AW-1:0] idx_press;
   logic [3:0]    valor_press;

   // Edge detection, capture qualification and next press value
   always_comb begin
      vez_sobe    = vez_jogador & ~vez_prev;
      vez_desce   = ~vez_jogador & vez_prev;
      // A rise in CAPTURA still accepts the entry shown in that same cycle
      cap_evento  = (leds_prev == '0) && (leds != '0) &&
                    (((estado == CAPTURA) && (!vez_jogador || vez_sobe)) ||
                     ((estado == AGUARDA) && !vez_jogador));
      // Leaving AGUARDA starts a new round, so a coincident entry goes to slot 0
      cap_base    = ((estado == AGUARDA) && vez_desce) ? '0 : num_capturadas;
      cap_grava   = cap_evento && $onehot(leds) && (cap_base < MAX_N);
      indice_prox = indice + 5'd1;
      idx_press   = (estado == PENSA) ? indice[AW-1:0] : indice_prox[AW-1:0];
      valor_press = mem[idx_press];
`ifdef JOGADOR_ERRO_INJETADO_EN
      if ((errar_na_jogada != '0) &&
          (errar_na_jogada == (((estado == PENSA) ? indice : indice_prox) + 5'd1)))
         valor_press = {valor_press[2:0], valor_press[3]};
`endif
   end

   // Capture buffer storage (contents need no reset)
   always_ff @(posedge clock) begin
      if (cap_grava)
         mem[cap_base[AW-1:0]] <= leds;
   end

   // Main control FSM with registered chaves and status flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado         <= IDLE;
         chaves         <= '0;
         erro_captura   <= 1'b0;
         overflow       <= 1'b0;
         num_capturadas <= '0;
         indice         <= '0;
         timer          <= '0;
         leds_prev      <= '0;
         vez_prev       <= 1'b0;
      end else begin
         leds_prev <= leds;
         vez_prev  <= vez_jogador;

         if (cap_evento && !$onehot(leds))
            erro_captura <= 1'b1;
         if (cap_evento && $onehot(leds) && (cap_base >= MAX_N))
            overflow <= 1'b1;
         if (cap_grava)
            num_capturadas <= cap_base + 5'd1;

         if (!habilitar) begin
            estado <= IDLE;
            chaves <= '0;
         end else if ((estado != IDLE) && (acertou || errou || timeout)) begin
            estado <= FIM;
            chaves <= '0;
         end else begin
            case (estado)
               IDLE: begin
                  estado         <= CAPTURA;
                  num_capturadas <= '0;
                  erro_captura   <= 1'b0;
                  overflow       <= 1'b0;
                  indice         <= '0;
               end
               CAPTURA: begin
                  if (vez_sobe) begin
                     if ((num_capturadas != '0) || cap_grava) begin
                        estado <= PENSA;
                        timer  <= 8'(T_THINK - 1);
                        indice <= '0;
                     end else begin
                        erro_captura <= 1'b1;
                     end
                  end
               end
               PENSA: begin
                  if (timer == '0) begin
                     estado <= PRESSIONA;
                     chaves <= valor_press;
                     timer  <= 8'(T_PRESS - 1);
                  end else begin
                     timer <= timer - 8'd1;
                  end
               end
               PRESSIONA: begin
                  if (timer == '0) begin
                     estado <= SOLTA;
                     chaves <= '0;
                     timer  <= 8'(T_GAP - 1);
                  end else begin
                     timer <= timer - 8'd1;
                  end
               end
               SOLTA: begin
                  if (timer == '0) begin
                     if (indice < MAX_N)
                        indice <= indice_prox;
                     if (indice_prox >= num_capturadas) begin
                        estado <= AGUARDA;
                     end else begin
                        estado <= PRESSIONA;
                        chaves <= valor_press;
                        timer  <= 8'(T_PRESS - 1);
                     end
                  end else begin
                     timer <= timer - 8'd1;
                  end
               end
               AGUARDA: begin
                  if (vez_desce) begin
                     estado         <= CAPTURA;
                     num_capturadas <= cap_grava ? 5'd1 : 5'd0;
                  end
               end
               FIM: begin
                  estado <= FIM;
               end
               default: begin
                  estado <= IDLE;
                  chaves <= '0;
               end
            endcase
         end
      end
   end

   // Status decoded from the state register
   always_comb begin
      ocupado   = (estado != IDLE) && (estado != FIM);
      db_estado = estado;
   end

endmodule

// File: tb/tb_jogador_automatico.sv
// Testbench for jogador_automatico (MAX_JOGADAS=4). Captured entries are
// queued as expected presses; a monitor pops and compares on each press start.
module tb_jogador_automatico;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       habilitar = 1'b0;
   logic [3:0] leds = 4'b0000;
   logic       vez_jogador = 1'b0;
   logic       acertou = 1'b0;
   logic       errou = 1'b0;
   logic       timeout = 1'b0;
`ifdef JOGADOR_ERRO_INJETADO_EN
   logic [4:0] errar_na_jogada = 5'd0;
`endif
   logic [3:0] chaves;
   logic       ocupado;
   logic       erro_captura;
   logic       overflow;
   logic [4:0] num_capturadas;
   logic [3:0] db_estado;

   int checks = 0;
   int errors = 0;
   logic [3:0] esperados[$];
   logic [3:0] chaves_ant = 4'b0000;

   jogador_automatico #(
      .MAX_JOGADAS(4),
      .T_PRESS(3),
      .T_GAP(3),
      .T_THINK(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .habilitar(habilitar),
      .leds(leds),
      .vez_jogador(vez_jogador),
      .acertou(acertou),
      .errou(errou),
      .timeout(timeout),
`ifdef JOGADOR_ERRO_INJETADO_EN
      .errar_na_jogada(errar_na_jogada),
`endif
      .chaves(chaves),
      .ocupado(ocupado),
      .erro_captura(erro_captura),
      .overflow(overflow),
      .num_capturadas(num_capturadas),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // Scoreboard monitor: every press start must match the oldest queued entry
   always @(negedge clock) begin
      if (reset && chaves != 4'b0000 && chaves_ant == 4'b0000) begin
         checks++;
         if (esperados.size() == 0) begin
            errors++;
            $display("FAIL press_value: chaves=%b but no press expected", chaves);
         end else begin
            logic [3:0] exp_v;
            exp_v = esperados.pop_front();
            if (chaves !== exp_v) begin
               errors++;
               $display("FAIL press_value: chaves=%b expected %b", chaves, exp_v);
            end
         end
      end
      chaves_ant = chaves;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Show one leds pulse (3 cycles on, 3 off); queue it if it should be replayed
   task automatic pulse_leds(input logic [3:0] v, input bit guardar);
      leds = v;
      if (guardar) esperados.push_back(v);
      repeat (3) @(negedge clock);
      leds = 4'b0000;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset;
      @(negedge clock);
      checks++;
      if (chaves !== 4'b0000 || db_estado !== 4'd0 || ocupado !== 1'b0 ||
          erro_captura !== 1'b0 || overflow !== 1'b0 || num_capturadas !== 5'd0) begin
         errors++;
         $display("FAIL reset_state: chaves=%b estado=%0d ocupado=%b erro=%b ovf=%b num=%0d expected all zero",
                  chaves, db_estado, ocupado, erro_captura, overflow, num_capturadas);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd0) begin
         errors++;
         $display("FAIL idle_hold: estado=%0d expected 0", db_estado);
      end
   endtask

   task automatic test_single_press;
      bit exp_on;
      habilitar = 1'b1;
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd1 || ocupado !== 1'b1 || num_capturadas !== 5'd0) begin
         errors++;
         $display("FAIL enter_captura: estado=%0d ocupado=%b num=%0d expected 1/1/0",
                  db_estado, ocupado, num_capturadas);
      end
      pulse_leds(4'b0001, 1'b1);
      checks++;
      if (num_capturadas !== 5'd1) begin
         errors++;
         $display("FAIL single_capture: num=%0d expected 1", num_capturadas);
      end
      vez_jogador = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clock);
         exp_on = (k >= 3 && k <= 5);
         checks++;
         if ((chaves != 4'b0000) !== exp_on) begin
            errors++;
            $display("FAIL single_timing k=%0d: chaves=%b expected pressed=%0d", k, chaves, exp_on);
         end
         if (k == 1) begin
            checks++;
            if (db_estado !== 4'd2) begin
               errors++;
               $display("FAIL single_pensa: estado=%0d expected 2", db_estado);
            end
         end
      end
      checks++;
      if (db_estado !== 4'd5) begin
         errors++;
         $display("FAIL single_aguarda: estado=%0d expected 5", db_estado);
      end
   endtask

   task automatic test_four_round;
      int np;
      vez_jogador = 1'b0;
      leds = 4'b0001;
      esperados.push_back(4'b0001);
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd1 || num_capturadas !== 5'd1) begin
         errors++;
         $display("FAIL fall_capture: estado=%0d num=%0d expected 1/1", db_estado, num_capturadas);
      end
      repeat (2) @(negedge clock);
      leds = 4'b0000;
      repeat (3) @(negedge clock);
      pulse_leds(4'b0010, 1'b1);
      pulse_leds(4'b0100, 1'b1);
      pulse_leds(4'b1000, 1'b1);
      checks++;
      if (num_capturadas !== 5'd4 || erro_captura !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL four_capture: num=%0d erro=%b ovf=%b expected 4/0/0",
                  num_capturadas, erro_captura, overflow);
      end
      vez_jogador = 1'b1;
      np = 0;
      for (int k = 1; k <= 27; k++) begin
         @(negedge clock);
         if (chaves != 4'b0000) np++;
         if (k == 26) begin
            checks++;
            if (db_estado !== 4'd4) begin
               errors++;
               $display("FAIL four_last_gap: estado=%0d expected 4", db_estado);
            end
         end
      end
      checks++;
      if (db_estado !== 4'd5 || np != 12 || esperados.size() != 0) begin
         errors++;
         $display("FAIL four_replay: estado=%0d press_cycles=%0d pending=%0d expected 5/12/0",
                  db_estado, np, esperados.size());
      end
   endtask

   task automatic test_overflow;
      int np;
      vez_jogador = 1'b0;
      @(negedge clock);
      pulse_leds(4'b1000, 1'b1);
      pulse_leds(4'b0100, 1'b1);
      pulse_leds(4'b0010, 1'b1);
      pulse_leds(4'b0001, 1'b1);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_early: ovf=%b expected 0", overflow);
      end
      pulse_leds(4'b1000, 1'b0);
      checks++;
      if (overflow !== 1'b1 || num_capturadas !== 5'd4 || erro_captura !== 1'b0) begin
         errors++;
         $display("FAIL overflow_flag: ovf=%b num=%0d erro=%b expected 1/4/0",
                  overflow, num_capturadas, erro_captura);
      end
      vez_jogador = 1'b1;
      np = 0;
      for (int k = 1; k <= 27; k++) begin
         @(negedge clock);
         if (chaves != 4'b0000) np++;
      end
      checks++;
      if (db_estado !== 4'd5 || np != 12 || esperados.size() != 0) begin
         errors++;
         $display("FAIL overflow_replay: estado=%0d press_cycles=%0d pending=%0d expected 5/12/0",
                  db_estado, np, esperados.size());
      end
   endtask

   task automatic test_empty_and_invalid;
      vez_jogador = 1'b0;
      @(negedge clock);
      habilitar = 1'b0;
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd0 || chaves !== 4'b0000 || ocupado !== 1'b0) begin
         errors++;
         $display("FAIL disable_idle: estado=%0d chaves=%b ocupado=%b expected 0/0000/0",
                  db_estado, chaves, ocupado);
      end
      habilitar = 1'b1;
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd1 || overflow !== 1'b0 || erro_captura !== 1'b0 || num_capturadas !== 5'd0) begin
         errors++;
         $display("FAIL flags_cleared: estado=%0d ovf=%b erro=%b num=%0d expected 1/0/0/0",
                  db_estado, overflow, erro_captura, num_capturadas);
      end
      vez_jogador = 1'b1;
      @(negedge clock);
      checks++;
      if (erro_captura !== 1'b1 || db_estado !== 4'd1) begin
         errors++;
         $display("FAIL empty_rise: erro=%b estado=%0d expected 1/1", erro_captura, db_estado);
      end
      vez_jogador = 1'b0;
      habilitar = 1'b0;
      @(negedge clock);
      habilitar = 1'b1;
      @(negedge clock);
      pulse_leds(4'b0011, 1'b0);
      checks++;
      if (erro_captura !== 1'b1 || num_capturadas !== 5'd0 || db_estado !== 4'd1) begin
         errors++;
         $display("FAIL invalid_leds: erro=%b num=%0d estado=%0d expected 1/0/1",
                  erro_captura, num_capturadas, db_estado);
      end
   endtask

   task automatic test_simultaneous;
      leds = 4'b0100;
      vez_jogador = 1'b1;
      esperados.push_back(4'b0100);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clock);
         leds = 4'b0000;
         if (k == 1) begin
            checks++;
            if (db_estado !== 4'd2 || num_capturadas !== 5'd1) begin
               errors++;
               $display("FAIL simult_capture: estado=%0d num=%0d expected 2/1", db_estado, num_capturadas);
            end
         end
      end
      checks++;
      if (db_estado !== 4'd5 || esperados.size() != 0) begin
         errors++;
         $display("FAIL simult_replay: estado=%0d pending=%0d expected 5/0", db_estado, esperados.size());
      end
   endtask

   task automatic test_result;
      vez_jogador = 1'b0;
      leds = 4'b0010;
      esperados.push_back(4'b0010);
      @(negedge clock);
      leds = 4'b0000;
      @(negedge clock);
      vez_jogador = 1'b1;
      repeat (4) @(negedge clock);
      checks++;
      if (chaves !== 4'b0010 || db_estado !== 4'd3) begin
         errors++;
         $display("FAIL result_pressing: chaves=%b estado=%0d expected 0010/3", chaves, db_estado);
      end
      errou = 1'b1;
      @(negedge clock);
      errou = 1'b0;
      checks++;
      if (chaves !== 4'b0000 || db_estado !== 4'd6 || ocupado !== 1'b0) begin
         errors++;
         $display("FAIL result_fim: chaves=%b estado=%0d ocupado=%b expected 0000/6/0",
                  chaves, db_estado, ocupado);
      end
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd6) begin
         errors++;
         $display("FAIL fim_hold: estado=%0d expected 6", db_estado);
      end
      habilitar = 1'b0;
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd0) begin
         errors++;
         $display("FAIL fim_exit: estado=%0d expected 0", db_estado);
      end
   endtask

   task automatic test_async_reset;
      vez_jogador = 1'b0;
      habilitar = 1'b1;
      @(negedge clock);
      leds = 4'b0100;
      esperados.push_back(4'b0100);
      @(negedge clock);
      leds = 4'b0000;
      @(negedge clock);
      vez_jogador = 1'b1;
      repeat (4) @(negedge clock);
      checks++;
      if (chaves !== 4'b0100) begin
         errors++;
         $display("FAIL areset_pre: chaves=%b expected 0100", chaves);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (chaves !== 4'b0000 || db_estado !== 4'd0 || num_capturadas !== 5'd0 || ocupado !== 1'b0) begin
         errors++;
         $display("FAIL areset_now: chaves=%b estado=%0d num=%0d ocupado=%b expected 0000/0/0/0",
                  chaves, db_estado, num_capturadas, ocupado);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd1 || chaves !== 4'b0000 || esperados.size() != 0) begin
         errors++;
         $display("FAIL areset_after: estado=%0d chaves=%b pending=%0d expected 1/0000/0",
                  db_estado, chaves, esperados.size());
      end
   endtask

`ifdef JOGADOR_ERRO_INJETADO_EN
   task automatic test_inject;
      errar_na_jogada = 5'd2;
      vez_jogador = 1'b0;
      @(negedge clock);
      pulse_leds(4'b0001, 1'b0);
      esperados.push_back(4'b0001);
      pulse_leds(4'b0010, 1'b0);
      esperados.push_back(4'b0100);
      vez_jogador = 1'b1;
      repeat (15) @(negedge clock);
      checks++;
      if (db_estado !== 4'd5 || esperados.size() != 0) begin
         errors++;
         $display("FAIL inject_replay: estado=%0d pending=%0d expected 5/0", db_estado, esperados.size());
      end
      errar_na_jogada = 5'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_press();
      test_four_round();
      test_overflow();
      test_empty_and_invalid();
      test_simultaneous();
      test_result();
      test_async_reset();
`ifdef JOGADOR_ERRO_INJETADO_EN
      test_inject();
`endif
      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Hardware auto-player for the memory game (Genius) circuit: the responder side of the game's leds/chaves interface.
- Watches `leds` while the game presents a round and records the displayed sequence.
- When `vez_jogador` rises, replays the sequence on `chaves` with fixed press/release timing, then waits for the next round or the end-of-game result.
- Sits beside the game core on the FPGA top level; enables long unattended regression runs and board self-tests.

Parameters:
- MAX_JOGADAS, 16: capacity of the capture buffer (entries of 4 bits).
- T_PRESS, 3: clock cycles each chave value is held.
- T_GAP, 3: clock cycles `chaves`=0000 between presses.
- T_THINK, 2: clock cycles from `vez_jogador` rising to the first press.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- habilitar  in  1  level; 1 = auto-player active, 0 = forced to IDLE.
- leds  in  4  game LED outputs (one-hot while a jogada is shown).
- vez_jogador  in  1  game is waiting for player input.
- acertou  in  1  game-won indication.
- errou  in  1  game-lost indication.
- timeout  in  1  game timeout indication.
- chaves  out  4  registered switch drive to the game.
- ocupado  out  1  1 in any state except IDLE and FIM.
- erro_captura  out  1  sticky: non-one-hot leds, or vez_jogador with empty buffer.
- overflow  out  1  sticky: capture attempted with buffer full.
- num_capturadas  out  5  entries captured this round.
- db_estado  out  4  current state code.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; chaves=0000; ocupado=0; erro_captura=0; overflow=0; num_capturadas=0; replay index=0.
  - Buffer contents are don't-care.
- State codes:
  - IDLE=0, CAPTURA=1, PENSA=2, PRESSIONA=3, SOLTA=4, AGUARDA=5, FIM=6.
- Capture event:
  - Definition: registered leds_prev==0000 and leds!=0000, evaluated in CAPTURA or AGUARDA with vez_jogador=0.
  - One-hot value: written to mem[num_capturadas]; num_capturadas+1 on the next edge.
  - Non-one-hot value: not stored; erro_captura<=1.
  - Buffer full (num_capturadas==MAX_JOGADAS): not stored; overflow<=1.
- Transitions:
  - IDLE: habilitar=1 -> CAPTURA; clear num_capturadas, erro_captura, overflow.
  - CAPTURA:
    - vez_jogador rising with num_capturadas>0 -> PENSA; load T_THINK timer; index=0.
    - vez_jogador rising with num_capturadas=0 -> erro_captura<=1; stay in CAPTURA.
  - PENSA: timer expires -> PRESSIONA; chaves<=mem[index].
  - PRESSIONA: after T_PRESS cycles -> SOLTA; chaves<=0000.
  - SOLTA: after T_GAP cycles, index+1:
    - index==num_capturadas -> AGUARDA.
    - otherwise -> PRESSIONA.
  - AGUARDA:
    - vez_jogador falling -> CAPTURA; num_capturadas<=0.
    - A capture event in the same cycle as that fall is stored at index 0.
  - Any state except IDLE:
    - acertou|errou|timeout=1 -> FIM; chaves<=0000 on that edge.
    - This has priority over every other transition.
  - FIM: holds while habilitar=1; habilitar=0 -> IDLE.
  - Any state: habilitar=0 -> IDLE on the next edge; chaves<=0000.
- Timing:
  - Replay of n entries lasts T_THINK + n*(T_PRESS+T_GAP) cycles, measured from the cycle after the vez_jogador rise is sampled.
  - `chaves` is a register; never glitches; exactly one bit set during PRESSIONA.
- Simultaneous events:
  - Capture event and vez_jogador rise in the same cycle: the entry is stored and included in the replay.
- leds changes outside CAPTURA/AGUARDA are ignored.
- Counter widths: num_capturadas and index saturate at MAX_JOGADAS; no wrap-around.

Optional Feature:
- Macro: JOGADOR_ERRO_INJETADO_EN.
- Defined:
  - Adds input `errar_na_jogada` [4:0].
  - When nonzero, the replayed entry with 1-based position == errar_na_jogada is driven as {v[2:0],v[3]} (rotate left).
  - This applies in every round long enough to contain that position; used to provoke errou deliberately.
- Not defined: port absent; replay is always faithful.

Test Plan:
- Reset mid-PRESSIONA (chaves=0100), reset=0 for 1 cycle -> chaves=0000, db_estado=0, num_capturadas=0 immediately, without waiting for a clock edge.
- habilitar=1, leds pulse 0001, vez_jogador rises -> chaves=0001 starts 2 cycles later and holds 3 cycles, then 0000 for 3 cycles; db_estado=5.
- 4-entry round (leds 0001,0010,0100,1000, each 3 cycles with 0000 gaps) -> replay in the same order; AGUARDA reached 2+4*6=26 cycles after the rise.
- Invalid capture: leds=0011 in CAPTURA -> erro_captura=1; num_capturadas unchanged. Empty buffer: vez_jogador rise with num_capturadas=0 -> erro_captura=1; state stays CAPTURA.
- MAX_JOGADAS=4, five one-hot pulses -> overflow=1, num_capturadas=4, four presses replayed.
- Result handling: errou pulse during PRESSIONA -> chaves=0000 and FIM next edge, ocupado=0. With JOGADOR_ERRO_INJETADO_EN and errar_na_jogada=2, capture 0001,0010 -> replay 0001,0100.
